// File: rtl/svc_rv_hazard_sb_pkg.sv
// Shared types for the scoreboarded hazard unit: scoreboard entry layout,
// memory-type encodings and the unit-select width helper.
package svc_rv_hazard_sb_pkg;

    localparam int REG_W = 5;

    localparam int MEM_TYPE_BRAM = 0;
    localparam int MEM_TYPE_SRAM = 1;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

    // Select width for n units; a single unit still gets a 1-bit select.
    function automatic int sb_luw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/svc_rv_hazard_sb_entry.sv
// One long-latency unit's scoreboard slot: valid/rd register, issue/done
// update and protocol-error detection.
module svc_rv_sb_entry
    import svc_rv_hazard_sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             done,
    output sb_entry_t        entry,
    output logic             err
);

    sb_entry_t entry_q;
    sb_entry_t entry_d;

    // Issue beats a same-cycle done so a unit can be reused back-to-back.
    always_comb begin
        entry_d = entry_q;
        if (issue) begin
            entry_d.valid = 1'b1;
            entry_d.rd    = issue_rd;
        end else if (done) begin
            entry_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;
    assign err   = (issue && entry_q.valid && !done) || (done && !entry_q.valid);

endmodule

// File: rtl/svc_rv_hazard_sb.sv
// Scoreboarded hazard unit beside ID: pipeline hazards plus RAW/WAW/structural
// stalls against in-flight long-latency ops, with error flag and stall counter.
module svc_rv_hazard_sb
    import svc_rv_hazard_sb_pkg::*;
#(
    parameter  int FWD_REGFILE = 1,
    parameter  int FWD         = 0,
    parameter  int MEM_TYPE    = MEM_TYPE_BRAM,
    parameter  int NUM_LU      = 2,
    parameter  int CNT_W       = 32,
    localparam int LUW         = sb_luw(NUM_LU)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [4:0]        rd_id,
    input  logic              reg_write_id,
    input  logic              lu_req_id,
    input  logic [LUW-1:0]    lu_sel_id,
    input  logic [4:0]        rd_ex,
    input  logic [4:0]        rd_mem,
    input  logic [4:0]        rd_wb,
    input  logic              reg_write_ex,
    input  logic              reg_write_mem,
    input  logic              reg_write_wb,
    input  logic              is_load_ex,
    input  logic              is_csr_ex,
    input  logic              lu_issue_valid,
    input  logic [LUW-1:0]    lu_issue_sel,
    input  logic [4:0]        lu_issue_rd,
    input  logic [NUM_LU-1:0] lu_done,
    input  logic              pc_sel,
    input  logic              mispredicted_ex,
    input  logic              pred_taken_id,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic [NUM_LU-1:0] lu_busy,
    output logic              sb_err,
    output logic [CNT_W-1:0]  stall_cycles
);

    function automatic logic reads_src(input logic [4:0] r, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic u1,
                                       input logic u2);
        return (r != 5'd0) && ((u1 && (s1 == r)) || (u2 && (s2 == r)));
    endfunction

    sb_entry_t         entries [NUM_LU];
    logic [NUM_LU-1:0] entry_err;

    for (genvar u = 0; u < NUM_LU; u++) begin : g_entry
        logic issue_u;
        assign issue_u = lu_issue_valid && (lu_issue_sel == LUW'(u));

        svc_rv_sb_entry u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .issue    (issue_u),
            .issue_rd (lu_issue_rd),
            .done     (lu_done[u]),
            .entry    (entries[u]),
            .err      (entry_err[u])
        );

        assign lu_busy[u] = entries[u].valid;
    end

    logic ex_hit, mem_hit, wb_hit;
    logic pipe_hazard;

    assign ex_hit  = reg_write_ex  && reads_src(rd_ex,  rs1_id, rs2_id, rs1_used, rs2_used);
    assign mem_hit = reg_write_mem && reads_src(rd_mem, rs1_id, rs2_id, rs1_used, rs2_used);
    assign wb_hit  = reg_write_wb  && reads_src(rd_wb,  rs1_id, rs2_id, rs1_used, rs2_used);

    // With forwarding only producers whose data is not yet available in EX stall.
    always_comb begin
        pipe_hazard = 1'b0;
        if (FWD != 0) begin
            pipe_hazard = ex_hit && (is_csr_ex || (is_load_ex && (MEM_TYPE == MEM_TYPE_BRAM)));
        end else begin
            pipe_hazard = ex_hit || mem_hit;
        end
        if (FWD_REGFILE == 0) begin
            pipe_hazard = pipe_hazard || wb_hit;
        end
    end

    logic lu_raw, lu_waw, lu_struct;

    // A done in the same cycle frees the unit but not its result register.
    always_comb begin
        lu_raw    = 1'b0;
        lu_waw    = 1'b0;
        lu_struct = 1'b0;
        for (int u = 0; u < NUM_LU; u++) begin
            if (entries[u].valid && reads_src(entries[u].rd, rs1_id, rs2_id, rs1_used, rs2_used)) begin
                lu_raw = 1'b1;
            end
            if (reg_write_id && (rd_id != 5'd0) && entries[u].valid && (entries[u].rd == rd_id)) begin
                lu_waw = 1'b1;
            end
            if (lu_req_id && (lu_sel_id == LUW'(u)) && entries[u].valid && !lu_done[u]) begin
                lu_struct = 1'b1;
            end
        end
    end

    logic data_hazard;
    assign data_hazard = pipe_hazard || lu_raw || lu_waw || lu_struct;

    assign pc_stall    = data_hazard;
    assign if_id_stall = data_hazard;
    assign id_ex_stall = 1'b0;
    assign if_id_flush = pc_sel || mispredicted_ex || (pred_taken_id && !data_hazard);
    assign id_ex_flush = data_hazard || pc_sel || mispredicted_ex;

    logic             sb_err_q, sb_err_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        sb_err_d       = sb_err_q || (|entry_err);
        stall_cycles_d = stall_cycles_q;
        if (data_hazard && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_err_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            sb_err_q       <= sb_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign sb_err       = sb_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_svc_rv_hazard_sb.sv
// Bench for svc_rv_hazard_sb: two configurations (no forwarding without regfile
// bypass; forwarding with 4-bit counter) checked against a behavioural model.
module tb_svc_rv_hazard_sb;

    localparam int NL  = 2;
    localparam int LUW = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0]     rs1_id, rs2_id, rd_id, rd_ex, rd_mem, rd_wb, lu_issue_rd;
    logic           rs1_used, rs2_used, reg_write_id, lu_req_id;
    logic [LUW-1:0] lu_sel_id, lu_issue_sel;
    logic           reg_write_ex, reg_write_mem, reg_write_wb, is_load_ex, is_csr_ex;
    logic           lu_issue_valid, pc_sel, mispredicted_ex, pred_taken_id;
    logic [NL-1:0]  lu_done;

    logic          pc_stall_a, if_id_stall_a, if_id_flush_a, id_ex_stall_a, id_ex_flush_a, sb_err_a;
    logic [NL-1:0] lu_busy_a;
    logic [31:0]   stall_a;
    logic          pc_stall_b, if_id_stall_b, if_id_flush_b, id_ex_stall_b, id_ex_flush_b, sb_err_b;
    logic [NL-1:0] lu_busy_b;
    logic [3:0]    stall_b;

    svc_rv_hazard_sb #(.FWD_REGFILE(0), .FWD(0), .MEM_TYPE(0), .NUM_LU(NL), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used),
        .rs2_used(rs2_used), .rd_id(rd_id), .reg_write_id(reg_write_id), .lu_req_id(lu_req_id),
        .lu_sel_id(lu_sel_id), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
        .is_load_ex(is_load_ex), .is_csr_ex(is_csr_ex), .lu_issue_valid(lu_issue_valid),
        .lu_issue_sel(lu_issue_sel), .lu_issue_rd(lu_issue_rd), .lu_done(lu_done),
        .pc_sel(pc_sel), .mispredicted_ex(mispredicted_ex), .pred_taken_id(pred_taken_id),
        .pc_stall(pc_stall_a), .if_id_stall(if_id_stall_a), .if_id_flush(if_id_flush_a),
        .id_ex_stall(id_ex_stall_a), .id_ex_flush(id_ex_flush_a), .lu_busy(lu_busy_a),
        .sb_err(sb_err_a), .stall_cycles(stall_a)
    );

    svc_rv_hazard_sb #(.FWD_REGFILE(1), .FWD(1), .MEM_TYPE(0), .NUM_LU(NL), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used),
        .rs2_used(rs2_used), .rd_id(rd_id), .reg_write_id(reg_write_id), .lu_req_id(lu_req_id),
        .lu_sel_id(lu_sel_id), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
        .is_load_ex(is_load_ex), .is_csr_ex(is_csr_ex), .lu_issue_valid(lu_issue_valid),
        .lu_issue_sel(lu_issue_sel), .lu_issue_rd(lu_issue_rd), .lu_done(lu_done),
        .pc_sel(pc_sel), .mispredicted_ex(mispredicted_ex), .pred_taken_id(pred_taken_id),
        .pc_stall(pc_stall_b), .if_id_stall(if_id_stall_b), .if_id_flush(if_id_flush_b),
        .id_ex_stall(id_ex_stall_b), .id_ex_flush(id_ex_flush_b), .lu_busy(lu_busy_b),
        .sb_err(sb_err_b), .stall_cycles(stall_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: which units hold an op and for which register.
    bit       m_valid [NL];
    bit [4:0] m_rd    [NL];
    bit       m_err;
    int unsigned m_cnt_a;
    int unsigned m_cnt_b;

    function automatic bit reads_reg(input bit [4:0] r);
        if (r == 0) return 0;
        return (rs1_used && rs1_id == r) || (rs2_used && rs2_id == r);
    endfunction

    function automatic bit pipe_hz(input bit fwd, input bit fwd_rf);
        if (!fwd_rf && reg_write_wb && reads_reg(rd_wb)) return 1;
        if (reg_write_ex && reads_reg(rd_ex)) begin
            if (!fwd || is_csr_ex || is_load_ex) return 1;
        end
        if (!fwd && reg_write_mem && reads_reg(rd_mem)) return 1;
        return 0;
    endfunction

    function automatic bit lu_hz();
        for (int u = 0; u < NL; u++) begin
            if (m_valid[u] && reads_reg(m_rd[u])) return 1;
            if (reg_write_id && rd_id != 0 && m_valid[u] && m_rd[u] == rd_id) return 1;
            if (lu_req_id && int'(lu_sel_id) == u && m_valid[u] && !lu_done[u]) return 1;
        end
        return 0;
    endfunction

    task automatic step();
        bit ha, hb, ctl;
        logic [NL-1:0] busy;
        #1;
        ha  = pipe_hz(0, 0) || lu_hz();
        hb  = pipe_hz(1, 1) || lu_hz();
        ctl = pc_sel || mispredicted_ex;
        for (int u = 0; u < NL; u++) busy[u] = m_valid[u];
        chk("a_pc_stall", 32'(pc_stall_a), 32'(ha));
        chk("a_if_id_stall", 32'(if_id_stall_a), 32'(ha));
        chk("a_if_id_flush", 32'(if_id_flush_a), 32'(ctl || (pred_taken_id && !ha)));
        chk("a_id_ex_stall", 32'(id_ex_stall_a), 32'd0);
        chk("a_id_ex_flush", 32'(id_ex_flush_a), 32'(ha || ctl));
        chk("a_lu_busy", 32'(lu_busy_a), 32'(busy));
        chk("a_sb_err", 32'(sb_err_a), 32'(m_err));
        chk("a_stall_cycles", stall_a, m_cnt_a);
        chk("b_pc_stall", 32'(pc_stall_b), 32'(hb));
        chk("b_if_id_stall", 32'(if_id_stall_b), 32'(hb));
        chk("b_if_id_flush", 32'(if_id_flush_b), 32'(ctl || (pred_taken_id && !hb)));
        chk("b_id_ex_stall", 32'(id_ex_stall_b), 32'd0);
        chk("b_id_ex_flush", 32'(id_ex_flush_b), 32'(hb || ctl));
        chk("b_lu_busy", 32'(lu_busy_b), 32'(busy));
        chk("b_sb_err", 32'(sb_err_b), 32'(m_err));
        chk("b_stall_cycles", 32'(stall_b), m_cnt_b);
        @(posedge clk);
        if (!rst_n) begin
            for (int u = 0; u < NL; u++) begin
                m_valid[u] = 0;
                m_rd[u]    = 0;
            end
            m_err   = 0;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            for (int u = 0; u < NL; u++) begin
                bit iss;
                iss = lu_issue_valid && int'(lu_issue_sel) == u;
                if ((iss && m_valid[u] && !lu_done[u]) || (lu_done[u] && !m_valid[u])) m_err = 1;
                if (iss) begin
                    m_valid[u] = 1;
                    m_rd[u]    = lu_issue_rd;
                end else if (lu_done[u]) begin
                    m_valid[u] = 0;
                end
            end
            if (ha && m_cnt_a != 32'hFFFF_FFFF) m_cnt_a++;
            if (hb && m_cnt_b != 15) m_cnt_b++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        {rs1_id, rs2_id, rd_id, rd_ex, rd_mem, rd_wb, lu_issue_rd} = '0;
        {rs1_used, rs2_used, reg_write_id, lu_req_id, lu_sel_id, lu_issue_sel} = '0;
        {reg_write_ex, reg_write_mem, reg_write_wb, is_load_ex, is_csr_ex} = '0;
        {lu_issue_valid, pc_sel, mispredicted_ex, pred_taken_id, lu_done} = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic issue(input int sel, input int rd);
        lu_issue_valid = 1'b1;
        lu_issue_sel   = LUW'(sel);
        lu_issue_rd    = 5'(rd);
        step();
        lu_issue_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        m_err = 0; m_cnt_a = 0; m_cnt_b = 0;
        for (int u = 0; u < NL; u++) begin m_valid[u] = 0; m_rd[u] = 0; end
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        do_reset();
        step();

        // RAW against unit0 holding x5, held through its done cycle.
        issue(0, 5);
        rs1_id = 5; rs1_used = 1;
        step();
        chk("raw_stall", 32'(pc_stall_a), 32'd1);
        step();
        lu_done = 2'b01;
        step();
        lu_done = 2'b00;
        step();
        chk("raw_release", 32'(pc_stall_a), 32'd0);
        idle();

        // WAW against unit1 holding x7.
        issue(1, 7);
        reg_write_id = 1; rd_id = 7; rs1_id = 2; rs2_id = 3; rs1_used = 1; rs2_used = 1;
        step(); step();
        lu_done = 2'b10;
        step();
        lu_done = 2'b00;
        step();
        idle();

        // Structural hazard, then done+reissue on unit0 in one cycle.
        issue(0, 9);
        lu_req_id = 1; lu_sel_id = 0;
        step();
        lu_done = 2'b01; lu_issue_valid = 1; lu_issue_sel = 0; lu_issue_rd = 10;
        step();
        idle();
        step();
        chk("reuse_busy", 32'(lu_busy_a[0]), 32'd1);
        chk("reuse_err", 32'(sb_err_a), 32'd0);

        // Control flow while unit0 busy must not drop the entry.
        pc_sel = 1;
        step();
        pc_sel = 0; mispredicted_ex = 1;
        step();
        mispredicted_ex = 0; pred_taken_id = 1;
        step();
        idle();
        lu_done = 2'b01;
        step();
        idle();

        // Spurious done on idle unit1, then issue to a busy unit.
        lu_done = 2'b10;
        step();
        lu_done = 2'b00;
        step(); step();
        chk("err_sticky", 32'(sb_err_b), 32'd1);
        do_reset();
        issue(0, 4);
        issue(0, 6);
        step();
        do_reset();

        // Load-use with forwarding: one stall only in the forwarding config.
        reg_write_ex = 1; is_load_ex = 1; rd_ex = 3; rs2_id = 3; rs2_used = 1;
        step();
        idle();
        step();
        chk("load_use_cnt", 32'(stall_b), 32'd1);
        reg_write_ex = 1; is_csr_ex = 1; rd_ex = 3; rs2_id = 3; rs2_used = 1;
        for (int i = 0; i < 20; i++) step();
        idle();
        step();
        chk("cnt_saturate", 32'(stall_b), 32'd15);
        do_reset();

        // Randomized traffic, mostly protocol-legal.
        for (int i = 0; i < 600; i++) begin
            idle();
            rst_n         = ($urandom_range(0, 149) != 0);
            rs1_id        = 5'($urandom_range(0, 7));
            rs2_id        = 5'($urandom_range(0, 7));
            rs1_used      = 1'($urandom);
            rs2_used      = 1'($urandom);
            rd_id         = 5'($urandom_range(0, 7));
            reg_write_id  = 1'($urandom);
            lu_req_id     = ($urandom_range(0, 2) == 0);
            lu_sel_id     = LUW'($urandom_range(0, NL - 1));
            rd_ex         = 5'($urandom_range(0, 7));
            rd_mem        = 5'($urandom_range(0, 7));
            rd_wb         = 5'($urandom_range(0, 7));
            reg_write_ex  = ($urandom_range(0, 2) == 0);
            reg_write_mem = ($urandom_range(0, 2) == 0);
            reg_write_wb  = ($urandom_range(0, 2) == 0);
            is_load_ex    = ($urandom_range(0, 3) == 0);
            is_csr_ex     = ($urandom_range(0, 5) == 0);
            pc_sel        = ($urandom_range(0, 7) == 0);
            mispredicted_ex = ($urandom_range(0, 7) == 0);
            pred_taken_id = ($urandom_range(0, 3) == 0);
            for (int u = 0; u < NL; u++) begin
                if (m_valid[u]) lu_done[u] = ($urandom_range(0, 3) == 0);
                else            lu_done[u] = ($urandom_range(0, 59) == 0);
            end
            lu_issue_sel = LUW'($urandom_range(0, NL - 1));
            lu_issue_rd  = 5'($urandom_range(0, 7));
            if (!m_valid[int'(lu_issue_sel)] || lu_done[int'(lu_issue_sel)])
                lu_issue_valid = ($urandom_range(0, 2) == 0);
            else
                lu_issue_valid = ($urandom_range(0, 59) == 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
